// File: rtl/multiplicador_pkg.sv
// Shared definitions for the parametrised shift-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    FIM  = 2'd3
  } state_t;

  // Counter must reach WIDTH itself, hence WIDTH+1 distinct values.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multiplicador_param_if.sv
// Start/done handshake and operand/result bus between the control unit
// (master) and the multiplier (slave).
interface multiplicador_param_if #(
  parameter int WIDTH = 4
);

  logic                 St;
  logic                 Sinal;
  logic [WIDTH-1:0]     Multiplicando;
  logic [WIDTH-1:0]     Multiplicador;
  logic                 Done;
  logic                 Idle;
  logic [2*WIDTH-1:0]   Produto;

  modport master (
    output St, Sinal, Multiplicando, Multiplicador,
    input  Done, Idle, Produto
  );

  modport slave (
    input  St, Sinal, Multiplicando, Multiplicador,
    output Done, Idle, Produto
  );

endinterface

// File: rtl/multiplicador_param_abs_neg.sv
// Combinational conditional two's-complement negate; with neg_i tied to the
// operand sign it yields the unsigned magnitude (the most negative value maps to 2^(WIDTH-1)).
module mult_abs_neg #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = neg_i ? (~a_i + 1'b1) : a_i;

endmodule

// File: rtl/multiplicador_param.sv
// Sequential shift-add multiplier, signed or unsigned, fixed latency of WIDTH+2
// edges from the start edge to the Done cycle.
module multiplicador_param
  import multiplicador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  multiplicador_param_if.slave bus
);

  localparam int CW = cntWidth(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [PW:0]       acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [PW-1:0]     prod_q, prod_d;

  logic [WIDTH-1:0]  magA, magB;
  logic [PW-1:0]     fixedProd;
  logic [WIDTH:0]    upperSum;

  mult_abs_neg #(.WIDTH(WIDTH)) uAbsA (
    .a_i   (bus.Multiplicando),
    .neg_i (bus.Sinal & bus.Multiplicando[WIDTH-1]),
    .y_o   (magA)
  );

  mult_abs_neg #(.WIDTH(WIDTH)) uAbsB (
    .a_i   (bus.Multiplicador),
    .neg_i (bus.Sinal & bus.Multiplicador[WIDTH-1]),
    .y_o   (magB)
  );

  mult_abs_neg #(.WIDTH(PW)) uFix (
    .a_i   (acc_q[PW-1:0]),
    .neg_i (neg_q),
    .y_o   (fixedProd)
  );

  // Upper WIDTH+1 bits absorb the carry of the partial-product add.
  assign upperSum = acc_q[PW:WIDTH] + {1'b0, mcand_q};

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (bus.St) begin
          state_d = CALC;
          mcand_d = magA;
          acc_d   = {{(WIDTH+1){1'b0}}, magB};
          cnt_d   = '0;
          neg_d   = bus.Sinal & (bus.Multiplicando[WIDTH-1] ^ bus.Multiplicador[WIDTH-1]);
        end
      end
      CALC: begin
        if (acc_q[0]) acc_d = {upperSum, acc_q[WIDTH-1:0]} >> 1;
        else          acc_d = acc_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        prod_d  = fixedProd;
        state_d = FIM;
      end
      FIM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.Done    = (state_q == FIM);
  assign bus.Idle    = (state_q == IDLE);
  assign bus.Produto = prod_q;

endmodule

// File: tb/tb_multiplicador_param.sv
// Bench for multiplicador_param: WIDTH=4 and WIDTH=8 instances checked every cycle
// against a latency/arithmetic model, plus directed vectors with literal results.
module tb_multiplicador_param;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  multiplicador_param_if #(.WIDTH(4)) bus4 ();
  multiplicador_param_if #(.WIDTH(8)) bus8 ();

  multiplicador_param #(.WIDTH(4)) dut4 (.Clk(Clk), .Rst(Rst), .bus(bus4));
  multiplicador_param #(.WIDTH(8)) dut8 (.Clk(Clk), .Rst(Rst), .bus(bus8));

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Plain arithmetic product, truncated to 2*w bits.
  function automatic logic [63:0] refMul(input int w, input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] mask;
    sa = longint'(a) & ((longint'(1) << w) - 1);
    sb = longint'(b) & ((longint'(1) << w) - 1);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = sa * sb;
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 64'(p) & mask;
  endfunction

  // Model: a start is accepted only when not busy; Done during the cycle after
  // edge start+W+1 (start edge counted as edge 1 = start+0); free again one edge later.
  int cyc = 0;
  bit busy4 = 0, busy8 = 0;
  int start4 = 0, start8 = 0;
  logic [63:0] res4 = 0, res8 = 0, prod4 = 0, prod8 = 0;

  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (Rst) begin
      busy4 = 0; prod4 = 0;
      busy8 = 0; prod8 = 0;
    end else begin
      if (!busy4) begin
        if (bus4.St) begin
          busy4 = 1; start4 = cyc;
          res4 = refMul(4, bus4.Sinal, 32'(bus4.Multiplicando), 32'(bus4.Multiplicador));
        end
      end else begin
        if (cyc == start4 + 4 + 1) prod4 = res4;
        if (cyc == start4 + 4 + 2) busy4 = 0;
      end
      if (!busy8) begin
        if (bus8.St) begin
          busy8 = 1; start8 = cyc;
          res8 = refMul(8, bus8.Sinal, 32'(bus8.Multiplicando), 32'(bus8.Multiplicador));
        end
      end else begin
        if (cyc == start8 + 8 + 1) prod8 = res8;
        if (cyc == start8 + 8 + 2) busy8 = 0;
      end
    end
  end

  always @(negedge Clk) begin
    if (cyc > 0) begin
      checkOutput("idle4", 64'(bus4.Idle), 64'(!busy4));
      checkOutput("done4", 64'(bus4.Done), 64'(busy4 && (cyc == start4 + 5)));
      checkOutput("prod4", 64'(bus4.Produto), prod4);
      checkOutput("idle8", 64'(bus8.Idle), 64'(!busy8));
      checkOutput("done8", 64'(bus8.Done), 64'(busy8 && (cyc == start8 + 9)));
      checkOutput("prod8", 64'(bus8.Produto), prod8);
    end
  end

  task automatic driveInputs(input int w, input bit st, input bit s, input logic [31:0] a, input logic [31:0] b);
    if (w == 4) begin
      bus4.St = st; bus4.Sinal = s; bus4.Multiplicando = a[3:0]; bus4.Multiplicador = b[3:0];
    end else begin
      bus8.St = st; bus8.Sinal = s; bus8.Multiplicando = a[7:0]; bus8.Multiplicador = b[7:0];
    end
  endtask

  function automatic bit doneOf(input int w);
    return (w == 4) ? bus4.Done : bus8.Done;
  endfunction

  // Pulse St for one cycle, then check latency, literal product and Idle return.
  task automatic applyStimulus(input int w, input bit s, input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] exp, input string name);
    int k;
    logic [63:0] got;
    @(negedge Clk);
    driveInputs(w, 1'b1, s, a, b);
    @(negedge Clk);
    driveInputs(w, 1'b0, s, a, b);
    k = 1;
    while (!doneOf(w) && k < 40) begin
      @(negedge Clk);
      k++;
    end
    got = (w == 4) ? 64'(bus4.Produto) : 64'(bus8.Produto);
    checkOutput({name, " latency"}, 64'(k), 64'(w + 2));
    checkOutput({name, " product"}, got, exp);
    @(negedge Clk);
    checkOutput({name, " idleAfter"}, 64'((w == 4) ? bus4.Idle : bus8.Idle), 64'd1);
  endtask

  initial begin
    int k;
    int doneSeen;
    Rst = 1'b1;
    driveInputs(4, 1'b0, 1'b0, 0, 0);
    driveInputs(8, 1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge Clk);
    checkOutput("reset idle4", 64'(bus4.Idle), 64'd1);
    checkOutput("reset prod4", 64'(bus4.Produto), 64'd0);
    Rst = 1'b0;

    applyStimulus(4, 1'b0, 3, 5, 64'h0F, "u 3x5");
    applyStimulus(4, 1'b0, 15, 15, 64'hE1, "u 15x15");
    applyStimulus(4, 1'b0, 12, 3, 64'h24, "u 12x3");
    applyStimulus(4, 1'b0, 0, 9, 64'h00, "u 0x9");
    applyStimulus(4, 1'b1, 32'hC, 3, 64'hF4, "s -4x3");
    applyStimulus(4, 1'b1, 32'h8, 32'h8, 64'h40, "s -8x-8");
    applyStimulus(4, 1'b1, 7, 32'hF, 64'hF9, "s 7x-1");
    applyStimulus(4, 1'b1, 32'h8, 7, 64'hC8, "s -8x7");

    // St held high; operands change mid-operation.
    @(negedge Clk);
    driveInputs(4, 1'b1, 1'b0, 3, 5);
    repeat (3) @(negedge Clk);
    driveInputs(4, 1'b1, 1'b0, 7, 7);
    k = 0;
    while (!bus4.Done && k < 40) begin @(negedge Clk); k++; end
    checkOutput("held first product", 64'(bus4.Produto), 64'h0F);
    k = 0;
    @(negedge Clk);
    k = 1;
    while (!bus4.Done && k < 40) begin @(negedge Clk); k++; end
    checkOutput("held spacing", 64'(k), 64'd7);
    checkOutput("held second product", 64'(bus4.Produto), 64'd49);
    driveInputs(4, 1'b0, 1'b0, 7, 7);
    repeat (3) @(negedge Clk);

    // Reset at the third CALC edge aborts the operation.
    driveInputs(4, 1'b1, 1'b0, 3, 5);
    @(negedge Clk);
    driveInputs(4, 1'b0, 1'b0, 3, 5);
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checkOutput("abort idle", 64'(bus4.Idle), 64'd1);
    checkOutput("abort done", 64'(bus4.Done), 64'd0);
    checkOutput("abort product", 64'(bus4.Produto), 64'd0);
    doneSeen = 0;
    repeat (12) begin
      @(negedge Clk);
      if (bus4.Done) doneSeen++;
    end
    checkOutput("abort noDone", 64'(doneSeen), 64'd0);
    applyStimulus(4, 1'b0, 3, 5, 64'h0F, "after abort 3x5");

    applyStimulus(8, 1'b0, 255, 255, 64'hFE01, "u8 255x255");
    applyStimulus(8, 1'b1, 32'h80, 32'h80, 64'h4000, "s8 -128x-128");
    applyStimulus(8, 1'b1, 32'hFF, 127, 64'hFF81, "s8 -1x127");

    repeat (2) @(negedge Clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
